// File: rtl/apb2axi_pkg.sv
// Shared types for the APB-to-AXI read path: descriptor layout and scheduler states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb2axi_pkg;

   localparam int CMD_TAG_W  = 4;
   localparam int CMD_ADDR_W = 32;
   localparam int CMD_LEN_W  = 8;

   // One read descriptor as queued by the directory FIFOs.
   typedef struct packed {
      logic [CMD_LEN_W-1:0]  len;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_TAG_W-1:0]  tag;
   } directory_entry_t;

   localparam int CMD_ENTRY_W = $bits(directory_entry_t);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } rd_sched_state_e;

endpackage

// File: rtl/apb2axi_rr_arbiter.sv
// Round-robin winner select over a request vector, starting after the last grant.
// Latency: combinational.
// Backpressure: none; grant is all-zero when no request is present.
// Optional: APB2AXI_RD_SCHED_PRIO_EN gives requester 0 absolute priority.
module apb2axi_rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_idx,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx
);

   logic [IDX_W-1:0] pos;
   logic             found;

   // Scan once around the ring starting just after the previous winner.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      pos     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         pos = IDX_W'((int'(last_idx) + i) % NUM_REQ);
         if (!found && req[pos]) begin
            found   = 1'b1;
            gnt_idx = pos;
         end
      end
`ifdef APB2AXI_RD_SCHED_PRIO_EN
      // Requester 0 overrides; with it idle the ring scan above already
      // rotates among the others since req[0] is low.
      if (req[0]) begin
         found   = 1'b1;
         gnt_idx = '0;
      end
`endif
      gnt[gnt_idx] = found;
   end

endmodule

// File: rtl/apb2axi_rd_scheduler.sv
// Picks one read descriptor from NUM_REQ FIFOs and offers it to the AR builder, limited by burst credit.
// Latency: 1 cycle from req_vld to rd_pop_vld; req_rdy pops the winner in the grant cycle.
// Backpressure: holds the offer until rd_pop_rdy; no new grant while offering or at MAX_OUTSTANDING.
// Optional: APB2AXI_RD_SCHED_PRIO_EN (fixed priority for requester 0, see arbiter).
module apb2axi_rd_scheduler
   import apb2axi_pkg::*;
#(
   parameter  int NUM_REQ         = 2,
   parameter  int FIFO_ENTRY_W    = CMD_ENTRY_W,
   parameter  int MAX_OUTSTANDING = 4,
   localparam int IDX_W           = $clog2(NUM_REQ),
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [NUM_REQ-1:0]              req_vld,
   input  logic [NUM_REQ*FIFO_ENTRY_W-1:0] req_data,
   output logic [NUM_REQ-1:0]              req_rdy,
   output logic                            rd_pop_vld,
   output logic [FIFO_ENTRY_W-1:0]         rd_pop_data,
   input  logic                            rd_pop_rdy,
   input  logic                            rlast_done,
   output logic [CNT_W-1:0]                outstanding_cnt,
   output logic [IDX_W-1:0]                grant_idx,
   output logic                            protocol_err
);

   rd_sched_state_e         state_q, state_d;
   logic [NUM_REQ-1:0]      arb_gnt;
   logic [IDX_W-1:0]        arb_idx;
   logic [FIFO_ENTRY_W-1:0] win_data;
   logic [CNT_W-1:0]        cnt_after_dec;
   logic                    issue;
   logic                    dec;
   logic                    grant;

   apb2axi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req      (req_vld),
      .last_idx (grant_idx),
      .gnt      (arb_gnt),
      .gnt_idx  (arb_idx)
   );

   // A completing burst frees its credit in the same cycle a new grant is judged.
   assign issue         = (state_q == OFFER) && rd_pop_rdy;
   assign dec           = rlast_done && (outstanding_cnt != '0);
   assign cnt_after_dec = outstanding_cnt - CNT_W'(dec);
   assign grant         = (state_q == IDLE) && !areset && (|req_vld) &&
                          (cnt_after_dec < CNT_W'(MAX_OUTSTANDING));
   assign rd_pop_vld    = (state_q == OFFER);

   // Route the winning requester's descriptor to the capture register.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_idx == IDX_W'(i)) begin
            win_data = req_data[i*FIFO_ENTRY_W +: FIFO_ENTRY_W];
         end
      end
   end

   // Next state and the single-cycle pop pulse to the winning FIFO.
   always_comb begin
      state_d = state_q;
      req_rdy = '0;
      case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = OFFER;
               req_rdy = arb_gnt;
            end
         end
         OFFER: begin
            if (rd_pop_rdy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the descriptor and remember the winner; reset drops any held offer.
   always_ff @(posedge aclk) begin
      if (areset) begin
         rd_pop_data <= '0;
         grant_idx   <= IDX_W'(NUM_REQ - 1);
      end else if (grant) begin
         rd_pop_data <= win_data;
         grant_idx   <= arb_idx;
      end
   end

   // Bursts in flight: +1 on accept, -1 on RLAST, unchanged when both coincide.
   always_ff @(posedge aclk) begin
      if (areset) begin
         outstanding_cnt <= '0;
      end else if (issue && !rlast_done) begin
         outstanding_cnt <= outstanding_cnt + CNT_W'(1);
      end else if (!issue && dec) begin
         outstanding_cnt <= outstanding_cnt - CNT_W'(1);
      end
   end

   // Sticky flag for an accept with nothing offered or an RLAST with nothing in flight.
   always_ff @(posedge aclk) begin
      if (areset) begin
         protocol_err <= 1'b0;
      end else if ((rd_pop_rdy && (state_q == IDLE)) ||
                   (rlast_done && !issue && (outstanding_cnt == '0))) begin
         protocol_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_apb2axi_rd_scheduler.sv
// Bench for apb2axi_rd_scheduler: two instances (MAX_OUTSTANDING 4 and 2) with private FIFOs.
// A queue-based model predicts every output each cycle; directed scenarios add literal checks.
// Randomized traffic with occasional resets closes the run.
module tb_apb2axi_rd_scheduler;
   import apb2axi_pkg::*;

   localparam int NR = 2;
   localparam int NI = 2;
   localparam int W  = CMD_ENTRY_W;

   logic            aclk;
   logic            areset;
   logic [NR-1:0]   req_vld     [NI];
   logic [NR*W-1:0] req_data    [NI];
   logic [NR-1:0]   req_rdy     [NI];
   logic            rd_pop_vld  [NI];
   logic [W-1:0]    rd_pop_data [NI];
   logic            rd_pop_rdy  [NI];
   logic            rlast_done  [NI];
   logic            gidx        [NI];
   logic            perr        [NI];
   logic [2:0]      cnt4;
   logic [1:0]      cnt2;
   logic [31:0]     cnt_w       [NI];

   assign cnt_w[0] = {29'd0, cnt4};
   assign cnt_w[1] = {30'd0, cnt2};

   apb2axi_rd_scheduler #(.NUM_REQ(NR), .FIFO_ENTRY_W(W), .MAX_OUTSTANDING(4)) u_dut4 (
      .aclk(aclk), .areset(areset), .req_vld(req_vld[0]), .req_data(req_data[0]),
      .req_rdy(req_rdy[0]), .rd_pop_vld(rd_pop_vld[0]), .rd_pop_data(rd_pop_data[0]),
      .rd_pop_rdy(rd_pop_rdy[0]), .rlast_done(rlast_done[0]), .outstanding_cnt(cnt4),
      .grant_idx(gidx[0]), .protocol_err(perr[0]));

   apb2axi_rd_scheduler #(.NUM_REQ(NR), .FIFO_ENTRY_W(W), .MAX_OUTSTANDING(2)) u_dut2 (
      .aclk(aclk), .areset(areset), .req_vld(req_vld[1]), .req_data(req_data[1]),
      .req_rdy(req_rdy[1]), .rd_pop_vld(rd_pop_vld[1]), .rd_pop_data(rd_pop_data[1]),
      .rd_pop_rdy(rd_pop_rdy[1]), .rlast_done(rlast_done[1]), .outstanding_cnt(cnt2),
      .grant_idx(gidx[1]), .protocol_err(perr[1]));

   int n_chk  = 0;
   int n_fail = 0;

   // Environment: descriptor FIFOs per (instance, requester), builder in-flight counters, logs.
   logic [W-1:0] fq   [NI*NR][$];
   int           glog [NI][$];
   logic [W-1:0] ilog [NI][$];
   int           bb_inf [NI];
   int           max_o  [NI];

   // Reference model state.
   bit           m_offer [NI];
   logic [W-1:0] m_data  [NI];
   int           m_last  [NI];
   int           m_cnt   [NI];
   bit           m_err   [NI];
   logic [NR-1:0] m_exp_rdy;
   int           m_win, m_eff;
   bit           m_acc;

   directory_entry_t e;

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
      end
   endtask

   function automatic logic [W-1:0] mk(input int tag, input int addr);
      directory_entry_t d;
      d.len  = 8'd0;
      d.addr = 32'(addr);
      d.tag  = 4'(tag);
      return d;
   endfunction

   // Winner rule: first valid requester after the last grant, wrapping.
   function automatic int pick(input logic [NR-1:0] v, input int last);
`ifdef APB2AXI_RD_SCHED_PRIO_EN
      if (v[0]) return 0;
`endif
      for (int i = 1; i <= NR; i++) begin
         if (v[(last + i) % NR]) return (last + i) % NR;
      end
      return -1;
   endfunction

   // Compare every output against the model, then advance the model for the coming edge.
   always @(negedge aclk) begin
      for (int k = 0; k < NI; k++) begin
         m_exp_rdy = '0;
         m_win     = -1;
         m_eff     = m_cnt[k] - ((rlast_done[k] && m_cnt[k] > 0) ? 1 : 0);
         if (!areset && !m_offer[k] && req_vld[k] != '0 && m_eff < max_o[k]) begin
            m_win     = pick(req_vld[k], m_last[k]);
            m_exp_rdy = NR'(1) << m_win;
         end
         check($sformatf("req_rdy%0d", k),    64'(req_rdy[k]),     64'(m_exp_rdy));
         check($sformatf("pop_vld%0d", k),    64'(rd_pop_vld[k]),  64'(m_offer[k]));
         check($sformatf("pop_data%0d", k),   64'(rd_pop_data[k]), 64'(m_data[k]));
         check($sformatf("out_cnt%0d", k),    64'(cnt_w[k]),       64'(m_cnt[k]));
         check($sformatf("grant_idx%0d", k),  64'(gidx[k]),        64'(m_last[k]));
         check($sformatf("proto_err%0d", k),  64'(perr[k]),        64'(m_err[k]));
         if (areset) begin
            m_offer[k] = 1'b0;
            m_data[k]  = '0;
            m_last[k]  = NR - 1;
            m_cnt[k]   = 0;
            m_err[k]   = 1'b0;
         end else begin
            m_acc = m_offer[k] && rd_pop_rdy[k];
            if (rd_pop_rdy[k] && !m_offer[k]) m_err[k] = 1'b1;
            if (m_acc) begin
               ilog[k].push_back(m_data[k]);
               m_offer[k] = 1'b0;
            end
            if (m_acc && !rlast_done[k]) begin
               m_cnt[k]++;
            end else if (!m_acc && rlast_done[k]) begin
               if (m_cnt[k] > 0) m_cnt[k]--;
               else m_err[k] = 1'b1;
            end
            if (m_win >= 0) begin
               m_offer[k] = 1'b1;
               m_data[k]  = fq[k*NR + m_win].pop_front();
               m_last[k]  = m_win;
               glog[k].push_back(m_win);
            end
         end
      end
   end

   task automatic drive();
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < NR; i++) begin
            req_vld[k][i]          = (fq[k*NR + i].size() != 0);
            req_data[k][i*W +: W]  = (fq[k*NR + i].size() != 0) ? fq[k*NR + i][0] : '0;
         end
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
      for (int k = 0; k < NI; k++) begin
         rd_pop_rdy[k] = 1'b0;
         rlast_done[k] = 1'b0;
      end
      drive();
   endtask

   // AR builder: return one RLAST for an earlier accept, and/or accept a current offer.
   task automatic builder(input int k, input bit acc_en, input bit rl_en);
      if (rl_en && bb_inf[k] > 0 && !areset) begin
         rlast_done[k] = 1'b1;
         bb_inf[k]--;
      end
      if (acc_en && rd_pop_vld[k] && !areset) begin
         rd_pop_rdy[k] = 1'b1;
         bb_inf[k]++;
      end
   endtask

   task automatic do_reset();
      areset = 1'b1;
      for (int i = 0; i < NI*NR; i++) fq[i].delete();
      for (int k = 0; k < NI; k++) bb_inf[k] = 0;
      tick();
      tick();
      areset = 1'b0;
      for (int k = 0; k < NI; k++) begin
         glog[k].delete();
         ilog[k].delete();
      end
   endtask

   initial begin
      int cnt_a;
      directory_entry_t t;
      max_o[0] = 4;
      max_o[1] = 2;
      areset = 1'b1;
      for (int k = 0; k < NI; k++) begin
         m_offer[k] = 1'b0; m_data[k] = '0; m_last[k] = NR - 1; m_cnt[k] = 0; m_err[k] = 1'b0;
         rd_pop_rdy[k] = 1'b0; rlast_done[k] = 1'b0; bb_inf[k] = 0;
      end
      drive();

      // Reset state.
      do_reset();
      for (int k = 0; k < NI; k++) begin
         check("rst_vld",  64'(rd_pop_vld[k]), 64'd0);
         check("rst_gidx", 64'(gidx[k]),       64'd1);
         check("rst_cnt",  64'(cnt_w[k]),      64'd0);
         check("rst_err",  64'(perr[k]),       64'd0);
      end

      // Single descriptor on requester 0.
      for (int k = 0; k < NI; k++) fq[k*NR].push_back(mk(3, 32'h1000));
      drive();
      #1;
      for (int k = 0; k < NI; k++) check("single_pop", 64'(req_rdy[k]), 64'd1);
      tick();
      for (int k = 0; k < NI; k++) begin
         e = directory_entry_t'(rd_pop_data[k]);
         check("single_vld",      64'(rd_pop_vld[k]), 64'd1);
         check("single_tag",      64'(e.tag),         64'd3);
         check("single_addr",     64'(e.addr),        64'h1000);
         check("single_pop_once", 64'(req_rdy[k]),    64'd0);
         builder(k, 1'b1, 1'b0);
      end
      tick();
      for (int k = 0; k < NI; k++) begin
         check("single_cnt",     64'(cnt_w[k]),       64'd1);
         check("single_ar_once", 64'(ilog[k].size()), 64'd1);
         check("single_no_dbl",  64'(rd_pop_vld[k]),  64'd0);
         builder(k, 1'b0, 1'b1);
      end
      tick();
      for (int k = 0; k < NI; k++) check("single_cnt_ret", 64'(cnt_w[k]), 64'd0);

      // Fairness: both requesters always valid, prompt RLAST.
      do_reset();
      for (int j = 0; j < 3; j++)
         for (int k = 0; k < NI; k++)
            for (int i = 0; i < NR; i++) fq[k*NR + i].push_back(mk(j*NR + i, 32'h100 * (j + 1)));
      drive();
      for (int c = 0; c < 100 && ilog[0].size() < 6; c++) begin
         for (int k = 0; k < NI; k++) builder(k, 1'b1, 1'b1);
         tick();
      end
      for (int k = 0; k < NI; k++) begin
         check("fair_count", 64'(glog[k].size()), 64'd6);
         for (int j = 0; j < 6; j++)
            check("fair_order", 64'((j < glog[k].size()) ? glog[k][j] : -1), 64'(j % 2));
      end

      // Credit stall: three queued, accepts but no RLAST.
      do_reset();
      for (int k = 0; k < NI; k++) begin
         fq[k*NR].push_back(mk(1, 32'h10));
         fq[k*NR + 1].push_back(mk(2, 32'h20));
         fq[k*NR].push_back(mk(3, 32'h30));
      end
      drive();
      repeat (30) begin
         for (int k = 0; k < NI; k++) builder(k, 1'b1, 1'b0);
         tick();
      end
      check("stall_grants_m2", 64'(glog[1].size()), 64'd2);
      check("stall_cnt_m2",    64'(cnt_w[1]),       64'd2);
      check("stall_vld_m2",    64'(rd_pop_vld[1]),  64'd0);
      check("stall_grants_m4", 64'(glog[0].size()), 64'd3);
      check("stall_cnt_m4",    64'(cnt_w[0]),       64'd3);
      #1;
      check("stall_no_pop", 64'(req_rdy[1]), 64'd0);
      builder(1, 1'b0, 1'b1);
      #1;
      check("stall_pop_with_rlast", 64'(req_rdy[1] != '0), 64'd1);
      tick();
      check("stall_third_vld", 64'(rd_pop_vld[1]), 64'd1);
      builder(1, 1'b1, 1'b0);
      tick();
      check("stall_cnt_after",    64'(cnt_w[1]),       64'd2);
      check("stall_grants_after", 64'(glog[1].size()), 64'd3);

      // Accept and RLAST in the same cycle at count 1.
      do_reset();
      for (int k = 0; k < NI; k++) begin
         fq[k*NR].push_back(mk(4, 32'h40));
         fq[k*NR].push_back(mk(5, 32'h50));
      end
      drive();
      for (int c = 0; c < 10 && !rd_pop_vld[0]; c++) tick();
      for (int k = 0; k < NI; k++) builder(k, 1'b1, 1'b0);
      tick();
      for (int c = 0; c < 10 && !rd_pop_vld[0]; c++) tick();
      for (int k = 0; k < NI; k++) begin
         check("simul_pre_cnt", 64'(cnt_w[k]), 64'd1);
         builder(k, 1'b1, 1'b1);
      end
      tick();
      for (int k = 0; k < NI; k++) begin
         check("simul_cnt", 64'(cnt_w[k]), 64'd1);
         check("simul_err", 64'(perr[k]),  64'd0);
      end

      // Protocol errors.
      do_reset();
      for (int k = 0; k < NI; k++) rlast_done[k] = 1'b1;
      tick();
      for (int k = 0; k < NI; k++) begin
         check("err_cnt_zero", 64'(cnt_w[k]), 64'd0);
         check("err_set",      64'(perr[k]),  64'd1);
      end
      repeat (5) tick();
      for (int k = 0; k < NI; k++) check("err_sticky", 64'(perr[k]), 64'd1);
      do_reset();
      for (int k = 0; k < NI; k++) check("err_clear", 64'(perr[k]), 64'd0);
      for (int k = 0; k < NI; k++) rd_pop_rdy[k] = 1'b1;
      tick();
      for (int k = 0; k < NI; k++) check("err_idle_accept", 64'(perr[k]), 64'd1);

      // Reset while an offer is held.
      do_reset();
      for (int k = 0; k < NI; k++) fq[k*NR + 1].push_back(mk(4'hA, 32'h2000));
      drive();
      for (int c = 0; c < 10 && !rd_pop_vld[0]; c++) tick();
      for (int k = 0; k < NI; k++) check("midrst_offer", 64'(rd_pop_vld[k]), 64'd1);
      areset = 1'b1;
      tick();
      for (int k = 0; k < NI; k++) begin
         check("midrst_vld",  64'(rd_pop_vld[k]),  64'd0);
         check("midrst_cnt",  64'(cnt_w[k]),       64'd0);
         check("midrst_data", 64'(rd_pop_data[k]), 64'd0);
      end
      areset = 1'b0;
      for (int k = 0; k < NI; k++) begin
         fq[k*NR].push_back(mk(1, 32'h3000));
         fq[k*NR + 1].push_back(mk(2, 32'h4000));
      end
      drive();
      #1;
      for (int k = 0; k < NI; k++) check("midrst_first_grant", 64'(req_rdy[k]), 64'd1);
      repeat (12) begin
         for (int k = 0; k < NI; k++) builder(k, 1'b1, 1'b1);
         tick();
      end
      for (int k = 0; k < NI; k++) begin
         cnt_a = 0;
         foreach (ilog[k][j]) begin
            t = directory_entry_t'(ilog[k][j]);
            if (t.tag == 4'hA) cnt_a++;
         end
         check("midrst_dropped", 64'(cnt_a),           64'd0);
         check("midrst_issued",  64'(ilog[k].size()), 64'd2);
      end

      // Randomized traffic with occasional resets.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         areset = 1'b0;
         for (int k = 0; k < NI; k++) begin
            if ($urandom_range(0, 2) == 0) begin
               int i;
               i = $urandom_range(0, NR - 1);
               if (fq[k*NR + i].size() < 4) begin
                  e.len  = 8'($urandom);
                  e.addr = $urandom;
                  e.tag  = 4'($urandom);
                  fq[k*NR + i].push_back(e);
               end
            end
         end
         drive();
         for (int k = 0; k < NI; k++)
            builder(k, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
         if ($urandom_range(0, 299) == 0) begin
            areset = 1'b1;
            for (int k = 0; k < NI; k++) bb_inf[k] = 0;
         end
         tick();
      end
      areset = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
